systolic_array: RTL

Parametrised output-stationary N x M systolic matrix-multiply array, the generalised successor of the fixed 2x2 MAC grid. It computes C = A x B for an N x K by K x M tile, with K programmable per job. Operands travel PE-to-PE through registers with internal input skewing. A job FSM handles start, operand-streaming handshake, pipeline flush and row-by-row result drain. It sits between the NPU operand buffers and the result writeback path.

---
 rtl/npu_pkg.sv | 23 ++
 rtl/systolic_pe.sv | 32 +++
 rtl/systolic_array.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types: job FSM states, default widths and the extended multiply
// used by the systolic processing elements.
package npu_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 32;
    localparam int DEF_KW = 16;

    // Operands up to 32 bits; the 64-bit product is exact mod 2^64 for both modes.
    function automatic logic [63:0] ext_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w, input logic sgn);
        logic [63:0] m, ax, bx;
        m  = (64'd1 << w) - 64'd1;
        ax = {32'd0, a} & m;
        bx = {32'd0, b} & m;
        if (sgn && ((ax & (64'd1 << (w - 1))) != 64'd0)) ax = ax | ~m;
        if (sgn && ((bx & (64'd1 << (w - 1))) != 64'd0)) bx = bx | ~m;
        return ax * bx;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary PE: forwards a right and b down, accumulates a*b each cycle.
module systolic_pe
    import npu_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          signed_mode,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [AW-1:0] acc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (clr) acc <= '0;
            else     acc <= acc + AW'(ext_mul(32'(a_in), 32'(b_in), DW, signed_mode));
        end
    end

endmodule

// File: rtl/systolic_array.sv
// N x M output-stationary matrix-multiply array with edge skewing, a job FSM
// (load / flush / row drain) and a ready/valid result port.
module systolic_array
    import npu_pkg::*;
#(
    parameter int N  = 2,
    parameter int M  = 2,
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int KW = DEF_KW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            signed_mode,
    output logic            busy,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_vec,
    input  logic [M*DW-1:0] b_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [M*AW-1:0] out_row,
    output logic            out_last
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = $clog2(N + M);

    state_t         state_q, state_d;
    logic [KW-1:0]  klen_q, klen_d, beat_q, beat_d;
    logic [FW-1:0]  fl_q, fl_d;
    logic [RW-1:0]  row_q, row_d;
    logic           sgn_q, sgn_d, clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            klen_q  <= '0;
            beat_q  <= '0;
            fl_q    <= '0;
            row_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            fl_q    <= fl_d;
            row_q   <= row_d;
            sgn_q   <= sgn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        klen_d    = klen_q;
        beat_d    = beat_q;
        fl_d      = fl_q;
        row_d     = row_q;
        sgn_d     = sgn_q;
        clr       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                klen_d  = k_len;
                sgn_d   = signed_mode;
                clr     = 1'b1;
                beat_d  = '0;
                row_d   = '0;
                state_d = (k_len == '0) ? DRAIN : LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == klen_q - KW'(1)) begin
                        fl_d    = '0;
                        state_d = FLUSH;
                    end
                end
            end
            // Long enough for the last beat to reach PE(N-1,M-1) through both skews.
            FLUSH: begin
                fl_d = fl_q + 1'b1;
                if (fl_q == FW'(N + M - 2)) state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (row_q == RW'(N - 1));
                if (out_ready) begin
                    row_d = row_q + 1'b1;
                    if (out_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Bubbles and non-LOAD cycles inject zeros, which add nothing to the sums.
    logic [N-1:0][DW-1:0] a_edge, a_sk;
    logic [M-1:0][DW-1:0] b_edge, b_sk;
    assign a_edge = (in_ready && in_valid) ? a_vec : '0;
    assign b_edge = (in_ready && in_valid) ? b_vec : '0;

    for (genvar i = 0; i < N; i++) begin : g_askew
        if (i == 0) begin : g_thru
            assign a_sk[i] = a_edge[i];
        end else begin : g_dly
            logic [i-1:0][DW-1:0] d;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) d <= '0;
                else begin
                    d[0] <= a_edge[i];
                    for (int k = 1; k < i; k++) d[k] <= d[k-1];
                end
            end
            assign a_sk[i] = d[i-1];
        end
    end

    for (genvar j = 0; j < M; j++) begin : g_bskew
        if (j == 0) begin : g_thru
            assign b_sk[j] = b_edge[j];
        end else begin : g_dly
            logic [j-1:0][DW-1:0] d;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) d <= '0;
                else begin
                    d[0] <= b_edge[j];
                    for (int k = 1; k < j; k++) d[k] <= d[k-1];
                end
            end
            assign b_sk[j] = d[j-1];
        end
    end

    logic [N-1:0][M:0][DW-1:0]   ah;
    logic [N:0][M-1:0][DW-1:0]   bv;
    logic [N-1:0][M-1:0][AW-1:0] acc;

    for (genvar i = 0; i < N; i++) begin : g_row
        assign ah[i][0] = a_sk[i];
        for (genvar j = 0; j < M; j++) begin : g_col
            if (i == 0) begin : g_btop
                assign bv[0][j] = b_sk[j];
            end
            systolic_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk         (clk),
                .rst         (rst),
                .clr         (clr),
                .signed_mode (sgn_q),
                .a_in        (ah[i][j]),
                .b_in        (bv[i][j]),
                .a_out       (ah[i][j+1]),
                .b_out       (bv[i+1][j]),
                .acc         (acc[i][j])
            );
        end
    end

    assign out_row = (state_q == DRAIN) ? acc[row_q] : '0;

endmodule
